// File: rtl/vram_access_arbiter.sv
// Arbitrates one single-port synchronous video RAM between the display fetch path
// (priority) and the CPU register path, with a starvation-forced CPU slot.
module vram_access_arbiter #(
    parameter int ADDR_W       = 12,
    parameter int DATA_W       = 8,
    parameter int STARVE_LIMIT = 8,
    parameter int CNT_W        = $clog2(STARVE_LIMIT + 1)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              disp_req_i,
    input  logic              disp_urgent_i,
    input  logic [ADDR_W-1:0] disp_addr_i,
    output logic              disp_gnt_o,
    output logic              disp_rvalid_o,
    output logic [DATA_W-1:0] disp_rdata_o,
    input  logic              cpu_req_i,
    input  logic              cpu_we_i,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    input  logic [DATA_W-1:0] cpu_wdata_i,
    output logic              cpu_gnt_o,
    output logic              cpu_rvalid_o,
    output logic [DATA_W-1:0] cpu_rdata_o,
    output logic              mem_en_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              starved_o
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0]  starve_cnt_q, starve_cnt_d;
    logic              force_slot;
    logic              rd_gnt;
    logic              mem_en_q, mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic [1:0]        tag_vld_q, tag_cpu_q;
    logic [DATA_W-1:0] disp_hold_q, cpu_hold_q;
    logic              starved_q;

    assign force_slot = cpu_req_i & ~disp_urgent_i & (starve_cnt_q == LIMIT);
    assign cpu_gnt_o  = cpu_req_i & (~disp_req_i | force_slot);
    assign disp_gnt_o = disp_req_i & ~force_slot;
    assign rd_gnt     = disp_gnt_o | (cpu_gnt_o & ~cpu_we_i);

    // Saturating at the limit also covers the urgent window: it parks there until urgent drops.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (!cpu_req_i || cpu_gnt_o)
            starve_cnt_d = '0;
        else if (starve_cnt_q != LIMIT)
            starve_cnt_d = starve_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            starve_cnt_q <= '0;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            tag_vld_q    <= '0;
            tag_cpu_q    <= '0;
            disp_hold_q  <= '0;
            cpu_hold_q   <= '0;
            starved_q    <= 1'b0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
            mem_en_q     <= disp_gnt_o | cpu_gnt_o;
            if (cpu_gnt_o) begin
                mem_we_q    <= cpu_we_i;
                mem_addr_q  <= cpu_addr_i;
                mem_wdata_q <= cpu_wdata_i;
            end else if (disp_gnt_o) begin
                mem_we_q    <= 1'b0;
                mem_addr_q  <= disp_addr_i;
                mem_wdata_q <= '0;
            end
            // Stage 0 lines up with the RAM command, stage 1 with the RAM read data.
            tag_vld_q <= {tag_vld_q[0], rd_gnt};
            tag_cpu_q <= {tag_cpu_q[0], cpu_gnt_o};
            if (disp_rvalid_o) disp_hold_q <= mem_rdata_i;
            if (cpu_rvalid_o)  cpu_hold_q  <= mem_rdata_i;
            starved_q <= starved_q | force_slot;
        end
    end

    assign mem_en_o    = mem_en_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign starved_o   = starved_q;

    assign disp_rvalid_o = tag_vld_q[1] & ~tag_cpu_q[1];
    assign cpu_rvalid_o  = tag_vld_q[1] & tag_cpu_q[1];

    // Read data is presented in the rvalid cycle and then held from the capture register.
    assign disp_rdata_o = disp_rvalid_o ? mem_rdata_i : disp_hold_q;
    assign cpu_rdata_o  = cpu_rvalid_o  ? mem_rdata_i : cpu_hold_q;

endmodule

// File: tb/tb_vram_access_arbiter.sv
// Bench for vram_access_arbiter: behavioural RAM, reference memory and per-channel
// scoreboards of expected read returns (data and due cycle).
module tb_vram_access_arbiter;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        disp_req_i, disp_urgent_i;
    logic [11:0] disp_addr_i;
    logic        disp_gnt_o, disp_rvalid_o;
    logic [7:0]  disp_rdata_o;
    logic        cpu_req_i, cpu_we_i;
    logic [11:0] cpu_addr_i;
    logic [7:0]  cpu_wdata_i;
    logic        cpu_gnt_o, cpu_rvalid_o;
    logic [7:0]  cpu_rdata_o;
    logic        mem_en_o, mem_we_o;
    logic [11:0] mem_addr_o;
    logic [7:0]  mem_wdata_o;
    logic [7:0]  mem_rdata_i = 8'h00;
    logic        starved_o;

    vram_access_arbiter #(.ADDR_W(12), .DATA_W(8), .STARVE_LIMIT(8)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .disp_req_i(disp_req_i), .disp_urgent_i(disp_urgent_i), .disp_addr_i(disp_addr_i),
        .disp_gnt_o(disp_gnt_o), .disp_rvalid_o(disp_rvalid_o), .disp_rdata_o(disp_rdata_o),
        .cpu_req_i(cpu_req_i), .cpu_we_i(cpu_we_i), .cpu_addr_i(cpu_addr_i),
        .cpu_wdata_i(cpu_wdata_i), .cpu_gnt_o(cpu_gnt_o), .cpu_rvalid_o(cpu_rvalid_o),
        .cpu_rdata_o(cpu_rdata_o), .mem_en_o(mem_en_o), .mem_we_o(mem_we_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i),
        .starved_o(starved_o)
    );

    always #5 clk = ~clk;

    logic [7:0] ram     [0:4095];
    logic [7:0] ref_mem [0:4095];

    always @(posedge clk) begin
        if (mem_en_o) begin
            if (mem_we_o) ram[mem_addr_o] <= mem_wdata_o;
            else          mem_rdata_i     <= ram[mem_addr_o];
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { logic [7:0] data; int due; } exp_t;
    exp_t disp_q[$];
    exp_t cpu_q[$];

    int n_cmp = 0;
    int n_bad = 0;
    int disp_ret = 0;
    int cpu_ret = 0;

    logic        p_cpu_req = 1'b0, p_cpu_gnt = 1'b0, p_cpu_we = 1'b0;
    logic [11:0] p_cpu_addr = '0;
    logic [7:0]  p_cpu_wdata = '0;
    logic        p_disp_req = 1'b0, p_disp_gnt = 1'b0;
    logic [11:0] p_disp_addr = '0;

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    // Negedge of the current cycle: retire returns, then record this cycle's grants.
    task automatic sb();
        exp_t e;
        @(negedge clk);
        if (disp_rvalid_o) begin
            disp_ret++;
            n_cmp++;
            if (disp_q.size() == 0) begin
                n_bad++;
                $display("FAIL disp_rvalid_unexpected: got data %h at cycle %0d, wanted no return", disp_rdata_o, cyc);
            end else begin
                e = disp_q.pop_front();
                if (disp_rdata_o !== e.data || cyc !== e.due) begin
                    n_bad++;
                    $display("FAIL disp_return: got data %h cycle %0d, wanted data %h cycle %0d", disp_rdata_o, cyc, e.data, e.due);
                end
            end
        end
        if (cpu_rvalid_o) begin
            cpu_ret++;
            n_cmp++;
            if (cpu_q.size() == 0) begin
                n_bad++;
                $display("FAIL cpu_rvalid_unexpected: got data %h at cycle %0d, wanted no return", cpu_rdata_o, cyc);
            end else begin
                e = cpu_q.pop_front();
                if (cpu_rdata_o !== e.data || cyc !== e.due) begin
                    n_bad++;
                    $display("FAIL cpu_return: got data %h cycle %0d, wanted data %h cycle %0d", cpu_rdata_o, cyc, e.data, e.due);
                end
            end
        end
        n_cmp++;
        if (disp_gnt_o && cpu_gnt_o) begin
            n_bad++;
            $display("FAIL gnt_exclusive: both grants high at cycle %0d, wanted at most one", cyc);
        end
        if (rst_i) begin
            disp_q.delete();
            cpu_q.delete();
            p_cpu_req  = 1'b0;
            p_disp_req = 1'b0;
        end else begin
            if (p_cpu_req && !p_cpu_gnt)
                assert (cpu_req_i && cpu_we_i == p_cpu_we && cpu_addr_i == p_cpu_addr && cpu_wdata_i == p_cpu_wdata)
                else $error("cpu request changed before grant");
            if (p_disp_req && !p_disp_gnt)
                assert (disp_req_i && disp_addr_i == p_disp_addr)
                else $error("display request changed before grant");
            if (disp_gnt_o) begin
                e.data = ref_mem[disp_addr_i];
                e.due  = cyc + 2;
                disp_q.push_back(e);
            end
            if (cpu_gnt_o) begin
                if (cpu_we_i) ref_mem[cpu_addr_i] = cpu_wdata_i;
                else begin
                    e.data = ref_mem[cpu_addr_i];
                    e.due  = cyc + 2;
                    cpu_q.push_back(e);
                end
            end
            p_cpu_req = cpu_req_i; p_cpu_gnt = cpu_gnt_o; p_cpu_we = cpu_we_i;
            p_cpu_addr = cpu_addr_i; p_cpu_wdata = cpu_wdata_i;
            p_disp_req = disp_req_i; p_disp_gnt = disp_gnt_o; p_disp_addr = disp_addr_i;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            sb();
            adv();
        end
    endtask

    task automatic check_drained(input string name);
        n_cmp++;
        if (disp_q.size() != 0 || cpu_q.size() != 0) begin
            n_bad++;
            $display("FAIL %s_drained: outstanding disp %0d cpu %0d, wanted 0 0", name, disp_q.size(), cpu_q.size());
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        adv();
        sb();
        n_cmp++;
        if ({mem_en_o, mem_we_o, disp_rvalid_o, cpu_rvalid_o, starved_o} !== 5'b0) begin
            n_bad++;
            $display("FAIL reset_flags: en/we/drv/crv/starved %b, wanted 00000",
                     {mem_en_o, mem_we_o, disp_rvalid_o, cpu_rvalid_o, starved_o});
        end
        n_cmp++;
        if (mem_addr_o !== 12'h000 || mem_wdata_o !== 8'h00) begin
            n_bad++;
            $display("FAIL reset_mem_bus: addr %h wdata %h, wanted 000 00", mem_addr_o, mem_wdata_o);
        end
        n_cmp++;
        if (disp_rdata_o !== 8'h00 || cpu_rdata_o !== 8'h00) begin
            n_bad++;
            $display("FAIL reset_rdata: disp %h cpu %h, wanted 00 00", disp_rdata_o, cpu_rdata_o);
        end
        rst_i = 1'b0;
        adv();
    endtask

    task automatic test_cpu_write();
        cpu_req_i = 1'b1; cpu_we_i = 1'b1; cpu_addr_i = 12'h010; cpu_wdata_i = 8'hA5;
        sb();
        n_cmp++;
        if (cpu_gnt_o !== 1'b1 || disp_gnt_o !== 1'b0) begin
            n_bad++;
            $display("FAIL write_gnt: cpu %b disp %b, wanted 1 0", cpu_gnt_o, disp_gnt_o);
        end
        adv();
        cpu_req_i = 1'b0; cpu_we_i = 1'b0;
        sb();
        n_cmp++;
        if ({mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o} !== {1'b1, 1'b1, 12'h010, 8'hA5}) begin
            n_bad++;
            $display("FAIL write_cmd: en %b we %b addr %h wdata %h, wanted 1 1 010 a5",
                     mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o);
        end
        adv();
        sb();
        n_cmp++;
        if (mem_en_o !== 1'b0 || mem_addr_o !== 12'h010) begin
            n_bad++;
            $display("FAIL idle_cmd_hold: en %b addr %h, wanted 0 010", mem_en_o, mem_addr_o);
        end
        adv();
        idle(3);
        check_drained("write");
    endtask

    task automatic test_cpu_read();
        int c0, d0;
        c0 = cpu_ret; d0 = disp_ret;
        cpu_req_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 12'h010;
        sb();
        n_cmp++;
        if (cpu_gnt_o !== 1'b1) begin
            n_bad++;
            $display("FAIL read_gnt: cpu %b, wanted 1", cpu_gnt_o);
        end
        adv();
        cpu_req_i = 1'b0;
        idle(4);
        n_cmp++;
        if (cpu_ret - c0 != 1 || disp_ret != d0 || cpu_rdata_o !== 8'hA5) begin
            n_bad++;
            $display("FAIL read_back: cpu returns %0d disp returns %0d held %h, wanted 1 0 a5",
                     cpu_ret - c0, disp_ret - d0, cpu_rdata_o);
        end
        check_drained("read");
    endtask

    task automatic test_interleave();
        int c0, d0;
        logic tgl;
        c0 = cpu_ret; d0 = disp_ret; tgl = 1'b0;
        for (int i = 0; i < 12; i++) begin
            disp_req_i  = (i % 3 != 2);
            disp_addr_i = {11'h0, tgl};
            if (i % 3 != 2) tgl = ~tgl;
            cpu_req_i  = (i % 3 == 2);
            cpu_we_i   = 1'b0;
            cpu_addr_i = 12'h002;
            sb();
            n_cmp++;
            if (disp_gnt_o !== disp_req_i || cpu_gnt_o !== cpu_req_i) begin
                n_bad++;
                $display("FAIL interleave_gnt[%0d]: disp %b cpu %b, wanted %b %b", i, disp_gnt_o, cpu_gnt_o, disp_req_i, cpu_req_i);
            end
            adv();
        end
        disp_req_i = 1'b0; cpu_req_i = 1'b0;
        idle(4);
        n_cmp++;
        if (disp_ret - d0 != 8 || cpu_ret - c0 != 4) begin
            n_bad++;
            $display("FAIL interleave_count: disp %0d cpu %0d returns, wanted 8 4", disp_ret - d0, cpu_ret - c0);
        end
        check_drained("interleave");
    endtask

    task automatic test_reset_midflight();
        int c0, d0;
        cpu_req_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 12'h002;
        sb();
        adv();
        cpu_addr_i = 12'h001; rst_i = 1'b1;
        sb();
        adv();
        rst_i = 1'b0; cpu_req_i = 1'b0;
        c0 = cpu_ret; d0 = disp_ret;
        sb();
        n_cmp++;
        if ({mem_en_o, mem_we_o, disp_rvalid_o, cpu_rvalid_o, starved_o} !== 5'b0 ||
            mem_addr_o !== 12'h000 || disp_rdata_o !== 8'h00 || cpu_rdata_o !== 8'h00) begin
            n_bad++;
            $display("FAIL midflight_outputs: en %b we %b rv %b%b st %b addr %h rd %h/%h, wanted all 0",
                     mem_en_o, mem_we_o, disp_rvalid_o, cpu_rvalid_o, starved_o, mem_addr_o, disp_rdata_o, cpu_rdata_o);
        end
        adv();
        idle(3);
        n_cmp++;
        if (cpu_ret != c0 || disp_ret != d0) begin
            n_bad++;
            $display("FAIL midflight_discard: %0d returns after reset, wanted 0", (cpu_ret - c0) + (disp_ret - d0));
        end
        cpu_req_i = 1'b1; cpu_addr_i = 12'h000;
        sb();
        n_cmp++;
        if (cpu_gnt_o !== 1'b1) begin
            n_bad++;
            $display("FAIL midflight_regrant: cpu_gnt %b, wanted 1", cpu_gnt_o);
        end
        adv();
        cpu_req_i = 1'b0;
        idle(4);
        check_drained("midflight");
    endtask

    task automatic test_urgent();
        disp_req_i = 1'b1; disp_urgent_i = 1'b1;
        cpu_req_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 12'h002;
        for (int i = 0; i < 20; i++) begin
            disp_addr_i = 12'(i % 2);
            sb();
            n_cmp++;
            if (cpu_gnt_o !== 1'b0 || starved_o !== 1'b0) begin
                n_bad++;
                $display("FAIL urgent_block[%0d]: cpu_gnt %b starved %b, wanted 0 0", i, cpu_gnt_o, starved_o);
            end
            adv();
        end
        disp_urgent_i = 1'b0;
        sb();
        n_cmp++;
        if (cpu_gnt_o !== 1'b1 || disp_gnt_o !== 1'b0) begin
            n_bad++;
            $display("FAIL urgent_release: cpu %b disp %b, wanted 1 0", cpu_gnt_o, disp_gnt_o);
        end
        adv();
        cpu_req_i = 1'b0;
        sb();
        n_cmp++;
        if (starved_o !== 1'b1) begin
            n_bad++;
            $display("FAIL urgent_starved: starved %b, wanted 1", starved_o);
        end
        adv();
        disp_req_i = 1'b0;
        idle(4);
        check_drained("urgent");
    endtask

    task automatic test_starvation();
        int  got;
        bit  done;
        rst_i = 1'b1;
        sb();
        adv();
        rst_i = 1'b0;
        disp_req_i = 1'b1; disp_urgent_i = 1'b0; disp_addr_i = 12'h001;
        cpu_req_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 12'h002;
        for (int r = 0; r < 2; r++) begin
            got = -1; done = 1'b0;
            for (int k = 0; k < 16 && !done; k++) begin
                sb();
                if (cpu_gnt_o) begin
                    got = k; done = 1'b1;
                    n_cmp++;
                    if (disp_gnt_o !== 1'b0) begin
                        n_bad++;
                        $display("FAIL starve_disp_stall[%0d]: disp_gnt %b, wanted 0", r, disp_gnt_o);
                    end
                end else if (r == 0) begin
                    n_cmp++;
                    if (starved_o !== 1'b0) begin
                        n_bad++;
                        $display("FAIL starve_early_flag: starved %b at wait %0d, wanted 0", starved_o, k);
                    end
                end
                adv();
            end
            n_cmp++;
            if (got != 8) begin
                n_bad++;
                $display("FAIL starve_slot[%0d]: cpu granted on wait index %0d, wanted 8 (-1 = timeout)", r, got);
            end
            cpu_addr_i = 12'h010;
        end
        cpu_req_i = 1'b0;
        sb();
        n_cmp++;
        if (starved_o !== 1'b1) begin
            n_bad++;
            $display("FAIL starve_flag: starved %b, wanted 1", starved_o);
        end
        adv();
        disp_req_i = 1'b0;
        idle(4);
        check_drained("starve");
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) begin
            ram[i]     = 8'(i) ^ 8'h5C;
            ref_mem[i] = 8'(i) ^ 8'h5C;
        end
        ram[0] = 8'h11; ram[1] = 8'h22; ram[2] = 8'h33;
        ref_mem[0] = 8'h11; ref_mem[1] = 8'h22; ref_mem[2] = 8'h33;
        rst_i = 1'b1;
        disp_req_i = 1'b0; disp_urgent_i = 1'b0; disp_addr_i = '0;
        cpu_req_i = 1'b0; cpu_we_i = 1'b0; cpu_addr_i = '0; cpu_wdata_i = '0;
        test_reset();
        test_cpu_write();
        test_cpu_read();
        test_interleave();
        test_reset_midflight();
        test_urgent();
        test_starvation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
